sel_sequencer: RTL and testbench

Round-robin select generator that drives the 2-bit `sel` input of the 4:1 mux stage. It replaces the free-running `sel <= sel + 1` counter with a controlled sequencer. Features:
- per-channel enable mask;
- programmable dwell (clock cycles per channel);
- start/stop control;
- slot and sweep strobes, so the downstream sampler knows when `sel` is stable and when a full pass over the enabled inputs has completed.

---
 rtl/sel_sequencer.sv | 165 ++++++++++++++++
 tb/tb_sel_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sel_sequencer.sv
// sel_sequencer: round-robin channel-select generator for the 4:1 mux stage.
// Walks the enabled channels in ascending order, holding each one for a
// programmable number of cycles, with start/stop control and strobes that
// mark slot starts and completed sweeps.
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   start       level, sampled in IDLE only
//   stop        level, sampled in RUN only
//   ch_en       channel enable mask, latched on start
//   dwell       cycles per slot (0 treated as 1), latched on start
//   sel         registered channel select
//   sel_valid   sel is a live slot
//   slot_start  pulse on first cycle of every slot
//   sweep_done  pulse on first cycle of the slot following a wrap
//   busy        high while running
module sel_sequencer #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [(1<<SEL_W)-1:0]   ch_en,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [SEL_W-1:0]        sel,
    output logic                    sel_valid,
    output logic                    slot_start,
    output logic                    sweep_done,
    output logic                    busy
);

    localparam int unsigned NCH = 1 << SEL_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                sel_valid_q, sel_valid_d;
    logic                slot_start_q, slot_start_d;
    logic                sweep_done_q, sweep_done_d;
    logic                busy_q, busy_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic                stop_pend_q, stop_pend_d;
    logic [NCH-1:0]      en_q, en_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;

    logic [DWELL_W-1:0]  dwell_eff;
    logic [SEL_W-1:0]    first_idx;
    logic [SEL_W-1:0]    nxt_idx;
    logic [SEL_W-1:0]    cand;
    logic                nxt_found;

    // Zero dwell behaves as a one-cycle slot.
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Lowest set bit of the incoming mask (scan high to low, last hit wins).
    always_comb begin
        first_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_en[i]) first_idx = SEL_W'(i);
        end
    end

    // Next enabled channel strictly above sel_q, searching circularly; the
    // final candidate (offset NCH) is sel_q itself for the single-channel case.
    always_comb begin
        nxt_idx   = sel_q;
        nxt_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = sel_q + SEL_W'(i);
            if (!nxt_found && en_q[cand]) begin
                nxt_idx   = cand;
                nxt_found = 1'b1;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        sel_valid_d  = sel_valid_q;
        slot_start_d = 1'b0;
        sweep_done_d = 1'b0;
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        stop_pend_d  = stop_pend_q;
        en_d         = en_q;
        dwell_d      = dwell_q;

        unique case (state_q)
            IDLE: begin
                if (start && (ch_en != '0)) begin
                    en_d         = ch_en;
                    dwell_d      = dwell_eff;
                    sel_d        = first_idx;
                    cnt_d        = DWELL_W'(dwell_eff - DWELL_W'(1));
                    sel_valid_d  = 1'b1;
                    slot_start_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = DWELL_W'(cnt_q - DWELL_W'(1));
                    if (stop) stop_pend_d = 1'b1;
                end else if (stop_pend_q || stop) begin
                    // Stop takes effect on the edge that would open the next slot.
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    sel_d        = nxt_idx;
                    sweep_done_d = (nxt_idx <= sel_q);
                    slot_start_d = 1'b1;
                    cnt_d        = DWELL_W'(dwell_q - DWELL_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            sel_valid_q  <= 1'b0;
            slot_start_q <= 1'b0;
            sweep_done_q <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            stop_pend_q  <= 1'b0;
            en_q         <= '0;
            dwell_q      <= DWELL_W'(1);
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            sel_valid_q  <= sel_valid_d;
            slot_start_q <= slot_start_d;
            sweep_done_q <= sweep_done_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            stop_pend_q  <= stop_pend_d;
            en_q         <= en_d;
            dwell_q      <= dwell_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign slot_start = slot_start_q;
    assign sweep_done = sweep_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sel_sequencer.sv
// Bench for sel_sequencer: a slot-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sel_sequencer;

    localparam int unsigned SEL_W   = 2;
    localparam int unsigned DWELL_W = 8;
    localparam int unsigned NCH     = 1 << SEL_W;

    logic               clk;
    logic               reset;
    logic               start;
    logic               stop;
    logic [NCH-1:0]     ch_en;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               slot_start;
    logic               sweep_done;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;

    sel_sequencer #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .ch_en      (ch_en),
        .dwell      (dwell),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .slot_start (slot_start),
        .sweep_done (sweep_done),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Tracks the running slot as (channel, age-in-slot) rather than a down-counter.
    bit       m_run;
    int       m_mask;
    int       m_len;
    int       m_age;
    bit       m_stop_req;
    int       e_sel;
    bit       e_valid, e_slot, e_sweep, e_busy;

    function automatic int lowest(input int mask);
        for (int k = 0; k < NCH; k++) if (mask[k]) return k;
        return 0;
    endfunction

    function automatic int next_ch(input int mask, input int cur);
        for (int k = 1; k <= NCH; k++) if (mask[(cur + k) % NCH]) return (cur + k) % NCH;
        return cur;
    endfunction

    always @(posedge clk) begin
        e_slot  = 0;
        e_sweep = 0;
        if (reset) begin
            m_run = 0; m_mask = 0; m_len = 1; m_age = 0; m_stop_req = 0;
            e_sel = 0; e_valid = 0; e_busy = 0;
        end else if (!m_run) begin
            if (start && ch_en != 0) begin
                m_mask = int'(ch_en);
                m_len  = (dwell == 0) ? 1 : int'(dwell);
                m_age  = 0;
                m_run  = 1;
                e_sel  = lowest(m_mask);
                e_valid = 1; e_slot = 1; e_busy = 1;
            end
        end else if (m_age == m_len - 1) begin
            if (m_stop_req || stop) begin
                m_run = 0; m_stop_req = 0; m_age = 0;
                e_valid = 0; e_busy = 0;
            end else begin
                int n;
                n = next_ch(m_mask, e_sel);
                e_sweep = (n <= e_sel);
                e_sel   = n;
                e_slot  = 1;
                m_age   = 0;
            end
        end else begin
            m_age++;
            if (stop) m_stop_req = 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("m_sel",        int'(sel),        e_sel);
        check("m_sel_valid",  int'(sel_valid),  int'(e_valid));
        check("m_slot_start", int'(slot_start), int'(e_slot));
        check("m_sweep_done", int'(sweep_done), int'(e_sweep));
        check("m_busy",       int'(busy),       int'(e_busy));
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic stop_and_wait();
        bit done;
        done = 0;
        stop = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            cyc();
            if (!busy) done = 1;
        end
        stop = 1'b0;
        check("stop_timeout", int'(done), 1);
    endtask

    initial begin
        int exp_sel[13];
        int sp_sel[4];
        int sp_sw[4];
        exp_sel = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
        sp_sel  = '{1,3,1,3};
        sp_sw   = '{0,0,1,0};

        reset = 1'b1; start = 1'b1; stop = 1'b0; ch_en = 4'b1111; dwell = 8'd3;
        cyc(); cyc();
        check("rst_busy", int'(busy), 0);
        reset = 1'b0; start = 1'b0;
        cyc(); cyc();
        check("idle_sel",   int'(sel), 0);
        check("idle_valid", int'(sel_valid), 0);
        check("idle_busy",  int'(busy), 0);

        // Full sweep, dwell 3.
        start = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cyc();
            start = 1'b0;
            check("sweep_sel",  int'(sel), exp_sel[i]);
            check("sweep_slot", int'(slot_start), (i % 3 == 0) ? 1 : 0);
            check("sweep_done", int'(sweep_done), (i == 12) ? 1 : 0);
        end
        stop_and_wait();

        // Sparse mask, dwell 0.
        ch_en = 4'b1010; dwell = 8'd0; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            start = 1'b0;
            check("sparse_sel",   int'(sel), sp_sel[i]);
            check("sparse_slot",  int'(slot_start), 1);
            check("sparse_sweep", int'(sweep_done), sp_sw[i]);
        end
        stop_and_wait();

        // Stop on 2nd cycle of sel=2 slot, with RUN-time input noise.
        ch_en = 4'b1111; dwell = 8'd4; start = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            cyc();
            if (i <= 12) check("stop_sel", int'(sel), (i <= 4) ? 0 : (i <= 8) ? 1 : 2);
            check("stop_valid", int'(sel_valid), (i <= 12) ? 1 : 0);
            if (i == 1) begin start = 1'b0; ch_en = 4'b0001; dwell = 8'd7; end
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
            if (i == 10) stop = 1'b1;
            if (i == 11) stop = 1'b0;
        end
        check("stop_hold_sel", int'(sel), 2);
        check("stop_busy",     int'(busy), 0);

        // Start with empty mask stays idle.
        ch_en = 4'b0000; start = 1'b1;
        cyc(); cyc();
        start = 1'b0;
        check("empty_busy",  int'(busy), 0);
        check("empty_sel",   int'(sel), 2);

        // Single channel, dwell 2, then reset mid-run.
        ch_en = 4'b0100; dwell = 8'd2; start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cyc();
            start = 1'b0;
            check("single_sel",   int'(sel), 2);
            check("single_slot",  int'(slot_start), (i % 2 == 1) ? 1 : 0);
            check("single_sweep", int'(sweep_done), (i % 2 == 1 && i > 1) ? 1 : 0);
        end
        reset = 1'b1;
        cyc();
        check("mrst_sel",   int'(sel), 0);
        check("mrst_valid", int'(sel_valid), 0);
        check("mrst_busy",  int'(busy), 0);
        reset = 1'b0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
